countdown_ctrl: RTL and testbench

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

---
 rtl/countdown_ctrl.sv | 150 +++++++++++++++
 tb/tb_countdown_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// Seconds countdown timer with pause/resume, a BCD display and a timed alarm phase.
// A prescaler turns CLK_HZ clock cycles into one-second ticks; every output is registered.
module countdown_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int ALARM_SECS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       alarm
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_HZ - 1);
  localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_SECS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    ALARM
  } state_t;

  state_t        state;
  logic [6:0]    count;
  logic [PW-1:0] prescaler;
  logic [AW-1:0] alarm_sec;
  logic          tick;
  logic [6:0]    clamped;

  assign tick    = (prescaler == PRE_MAX);
  assign clamped = (load_val > 7'd99) ? 7'd99 : load_val;

  function automatic logic [7:0] to_bcd(input logic [6:0] value);
    return {4'(value / 7'd10), 4'(value % 7'd10)};
  endfunction

  // Display digits are updated on the same edge as count, so they never lag it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 7'd0;
      prescaler <= '0;
      alarm_sec <= '0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      running   <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state       <= IDLE;
        count       <= 7'd0;
        prescaler   <= '0;
        alarm_sec   <= '0;
        {tens, ones} <= 8'h00;
        running     <= 1'b0;
        paused      <= 1'b0;
        alarm       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!pause) begin
              if (start) begin
                if (count != 7'd0) begin
                  state     <= RUN;
                  prescaler <= '0;
                  running   <= 1'b1;
                end
              end else if (load) begin
                count        <= clamped;
                {tens, ones} <= to_bcd(clamped);
              end
            end
          end

          // A pause arriving on a tick edge wins and that tick is lost.
          RUN: begin
            if (pause) begin
              state   <= PAUSE;
              running <= 1'b0;
              paused  <= 1'b1;
            end else if (tick) begin
              prescaler <= '0;
              if (count == 7'd1) begin
                state        <= ALARM;
                count        <= 7'd0;
                {tens, ones} <= 8'h00;
                done         <= 1'b1;
                running      <= 1'b0;
                alarm        <= 1'b1;
                alarm_sec    <= '0;
              end else begin
                count        <= count - 7'd1;
                {tens, ones} <= to_bcd(count - 7'd1);
              end
            end else begin
              prescaler <= prescaler + PW'(1);
            end
          end

          // The resume edge counts as a running cycle; a prescaler frozen at its
          // last value stays there so the pending tick fires on the next edge.
          PAUSE: begin
            if (start && !pause) begin
              state   <= RUN;
              running <= 1'b1;
              paused  <= 1'b0;
              if (prescaler != PRE_MAX) begin
                prescaler <= prescaler + PW'(1);
              end
            end
          end

          ALARM: begin
            if (tick) begin
              prescaler <= '0;
              if (alarm_sec == ALARM_MAX) begin
                state     <= IDLE;
                alarm     <= 1'b0;
                alarm_sec <= '0;
              end else begin
                alarm_sec <= alarm_sec + AW'(1);
              end
            end else begin
              prescaler <= prescaler + PW'(1);
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: a seconds-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_countdown_ctrl;

  localparam int CLK_HZ     = 4;
  localparam int ALARM_SECS = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [6:0] load_val;
  logic       start;
  logic       pause;
  logic       clear;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       paused;
  logic       done;
  logic       alarm;

  int checks_total  = 0;
  int checks_passed = 0;

  int m_mode       = M_IDLE;
  int m_secs       = 0;
  int m_phase      = 0;
  int m_alarm_left = 0;
  int m_done       = 0;
  int prev_done    = 0;

  countdown_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .ALARM_SECS(ALARM_SECS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .tens    (tens),
    .ones    (ones),
    .running (running),
    .paused  (paused),
    .done    (done),
    .alarm   (alarm)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model works in whole seconds, cycles into the current second, and seconds of alarm left.
  task automatic modelStep(input bit l, input int v, input bit s, input bit p, input bit c);
    m_done = 0;
    if (c) begin
      m_mode       = M_IDLE;
      m_secs       = 0;
      m_phase      = 0;
      m_alarm_left = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (!p) begin
            if (s) begin
              if (m_secs > 0) begin
                m_mode  = M_RUN;
                m_phase = 0;
              end
            end else if (l) begin
              m_secs = (v > 99) ? 99 : v;
            end
          end
        end
        M_RUN: begin
          if (p) begin
            m_mode = M_PAUSE;
          end else if (m_phase == CLK_HZ - 1) begin
            m_phase = 0;
            m_secs  = m_secs - 1;
            if (m_secs == 0) begin
              m_done       = 1;
              m_mode       = M_ALARM;
              m_alarm_left = ALARM_SECS;
            end
          end else begin
            m_phase = m_phase + 1;
          end
        end
        M_PAUSE: begin
          if (s && !p) begin
            m_mode  = M_RUN;
            m_phase = (m_phase + 1 > CLK_HZ - 1) ? CLK_HZ - 1 : m_phase + 1;
          end
        end
        default: begin
          if (m_phase == CLK_HZ - 1) begin
            m_phase      = 0;
            m_alarm_left = m_alarm_left - 1;
            if (m_alarm_left == 0) m_mode = M_IDLE;
          end else begin
            m_phase = m_phase + 1;
          end
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode       = M_IDLE;
      m_secs       = 0;
      m_phase      = 0;
      m_alarm_left = 0;
      m_done       = 0;
    end else begin
      modelStep(load, int'(load_val), start, pause, clear);
    end
    #1;
    checkOutput("model_tens", int'(tens), m_secs / 10);
    checkOutput("model_ones", int'(ones), m_secs % 10);
    checkOutput("model_running", int'(running), int'(m_mode == M_RUN));
    checkOutput("model_paused", int'(paused), int'(m_mode == M_PAUSE));
    checkOutput("model_alarm", int'(alarm), int'(m_mode == M_ALARM));
    checkOutput("model_done", int'(done), m_done);
    if (prev_done != 0) checkOutput("done_twice", int'(done), 0);
    prev_done = int'(done);
  end

  task automatic applyStimulus(input bit l, input logic [6:0] v, input bit s, input bit p,
                               input bit c);
    @(negedge clk);
    load     = l;
    load_val = v;
    start    = s;
    pause    = p;
    clear    = c;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    load_val = 7'd0;
    start    = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_tens", int'(tens), 0);
    checkOutput("rst_ones", int'(ones), 0);
    checkOutput("rst_running", int'(running), 0);
    checkOutput("rst_alarm", int'(alarm), 0);
    rst_n = 1'b1;

    // Load 10, one tick later the display reads 09.
    applyStimulus(1, 7'd10, 0, 0, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    checkOutput("load10_tens", int'(tens), 1);
    checkOutput("load10_ones", int'(ones), 0);
    applyStimulus(0, 7'd0, 1, 0, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    checkOutput("start10_running", int'(running), 1);
    repeat (3) @(negedge clk);
    checkOutput("pre_tick_tens", int'(tens), 1);
    @(negedge clk);
    checkOutput("tick_tens", int'(tens), 0);
    checkOutput("tick_ones", int'(ones), 9);
    applyStimulus(0, 7'd0, 0, 0, 1);
    applyStimulus(0, 7'd0, 0, 0, 0);
    checkOutput("clear_ones", int'(ones), 0);
    checkOutput("clear_running", int'(running), 0);

    // Full run from 3 through the two-second alarm.
    applyStimulus(1, 7'd3, 0, 0, 0);
    applyStimulus(0, 7'd0, 1, 0, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    repeat (4) @(negedge clk);
    checkOutput("e4_ones", int'(ones), 2);
    repeat (4) @(negedge clk);
    checkOutput("e8_ones", int'(ones), 1);
    repeat (4) @(negedge clk);
    checkOutput("e12_ones", int'(ones), 0);
    checkOutput("e12_done", int'(done), 1);
    checkOutput("e12_alarm", int'(alarm), 1);
    @(negedge clk);
    checkOutput("e13_done", int'(done), 0);
    repeat (6) @(negedge clk);
    checkOutput("e19_alarm", int'(alarm), 1);
    @(negedge clk);
    checkOutput("e20_alarm", int'(alarm), 0);
    checkOutput("e20_running", int'(running), 0);

    // Clamp to 99, then a zero count refuses to start.
    applyStimulus(1, 7'd120, 0, 0, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    checkOutput("clamp_tens", int'(tens), 9);
    checkOutput("clamp_ones", int'(ones), 9);
    applyStimulus(1, 7'd0, 0, 0, 0);
    applyStimulus(0, 7'd0, 1, 0, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("zero_start_running", int'(running), 0);

    // Pause for ten edges and resume; the next decrement lands two edges after resume.
    applyStimulus(1, 7'd25, 0, 0, 0);
    applyStimulus(0, 7'd0, 1, 0, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    repeat (4) @(negedge clk);
    checkOutput("p_e4_ones", int'(ones), 4);
    applyStimulus(0, 7'd0, 0, 1, 0);
    repeat (9) @(negedge clk);
    checkOutput("p_hold_paused", int'(paused), 1);
    checkOutput("p_hold_ones", int'(ones), 4);
    applyStimulus(0, 7'd0, 1, 0, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    checkOutput("p_r_running", int'(running), 1);
    @(negedge clk);
    checkOutput("p_r1_ones", int'(ones), 4);
    @(negedge clk);
    checkOutput("p_r2_ones", int'(ones), 3);
    checkOutput("p_r2_tens", int'(tens), 2);

    // Pause beats start in RUN; clear beats start in IDLE.
    applyStimulus(0, 7'd0, 1, 1, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    checkOutput("ps_paused", int'(paused), 1);
    checkOutput("ps_running", int'(running), 0);
    applyStimulus(0, 7'd0, 0, 0, 1);
    applyStimulus(1, 7'd5, 0, 0, 0);
    applyStimulus(0, 7'd0, 1, 0, 1);
    applyStimulus(0, 7'd0, 0, 0, 0);
    checkOutput("cs_ones", int'(ones), 0);
    checkOutput("cs_running", int'(running), 0);

    // Asynchronous reset mid-RUN, checked before any clock edge.
    applyStimulus(1, 7'd42, 0, 0, 0);
    applyStimulus(0, 7'd0, 1, 0, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("run42_tens", int'(tens), 4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_run_tens", int'(tens), 0);
    checkOutput("arst_run_running", int'(running), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset follows IDLE rules; then reset during ALARM.
    applyStimulus(1, 7'd1, 0, 0, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    checkOutput("post_rst_ones", int'(ones), 1);
    applyStimulus(0, 7'd0, 1, 0, 0);
    applyStimulus(0, 7'd0, 0, 0, 0);
    repeat (5) @(negedge clk);
    checkOutput("in_alarm", int'(alarm), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_alarm", int'(alarm), 0);
    checkOutput("arst_alarm_ones", int'(ones), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
